mips_bus_mem_unit: RTL and testbench

//   Load/store bus interface unit between the mips_cpu_bus execute stage and the Avalon-MM master port.

---
 rtl/mips_bus_mem_unit.sv | 166 ++++++++++++++++
 tb/tb_mips_bus_mem_unit.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mips_bus_mem_unit.sv
// Load/store bus interface unit: turns one CPU byte/half/word request into a
// single Avalon-MM read or write and returns exactly one response per request.
// Misaligned or reserved-size requests and bus timeouts come back as errors so
// the CPU is never left waiting.
//
// state | meaning
// IDLE  | req_ready=1, waiting for a request
// BUS   | Avalon strobe asserted, waiting for waitrequest=0 or timeout
// RESP  | one-cycle resp_valid pulse, then back to IDLE
module mips_bus_mem_unit #(
  parameter int TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  input  logic        waitrequest,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata
);

  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

  state_t        state;
  logic [CW-1:0] counter;
  logic [1:0]    off_q;
  logic [1:0]    size_q;
  logic          signed_q;
  logic          write_q;

  logic          req_bad;
  logic [3:0]    be_calc;
  logic [31:0]   wd_calc;
  logic [31:0]   shifted;
  logic [31:0]   load_ext;

  // Classify the incoming request and build its lane enables and replicated store data
  always_comb begin
    req_bad = (req_size == 2'b11)
            | ((req_size == 2'b01) & req_addr[0])
            | ((req_size == 2'b10) & (|req_addr[1:0]));
    be_calc = 4'b1111;
    wd_calc = req_wdata;
    case (req_size)
      2'b00: begin
        be_calc = 4'b0001 << req_addr[1:0];
        wd_calc = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be_calc = 4'b0011 << req_addr[1:0];
        wd_calc = {2{req_wdata[15:0]}};
      end
      default: begin
        be_calc = 4'b1111;
        wd_calc = req_wdata;
      end
    endcase
  end

  // Pick the addressed lane(s) out of readdata and extend to 32 bits
  always_comb begin
    shifted  = readdata >> {off_q, 3'b000};
    load_ext = readdata;
    case (size_q)
      2'b00:   load_ext = signed_q ? {{24{shifted[7]}}, shifted[7:0]} : {24'b0, shifted[7:0]};
      2'b01:   load_ext = signed_q ? {{16{shifted[15]}}, shifted[15:0]} : {16'b0, shifted[15:0]};
      default: load_ext = readdata;
    endcase
  end

  // Request/bus/response sequencer; every output is a register written here
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_IDLE;
      counter    <= '0;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_error <= 1'b0;
      resp_rdata <= '0;
      address    <= '0;
      read       <= 1'b0;
      write      <= 1'b0;
      writedata  <= '0;
      byteenable <= '0;
      off_q      <= '0;
      size_q     <= '0;
      signed_q   <= 1'b0;
      write_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            off_q     <= req_addr[1:0];
            size_q    <= req_size;
            signed_q  <= req_signed;
            write_q   <= req_write;
            if (req_bad) begin
              // rejected without ever touching the bus
              state      <= S_RESP;
              resp_valid <= 1'b1;
              resp_error <= 1'b1;
              resp_rdata <= '0;
            end else begin
              state      <= S_BUS;
              counter    <= '0;
              read       <= ~req_write;
              write      <= req_write;
              address    <= {req_addr[31:2], 2'b00};
              byteenable <= be_calc;
              writedata  <= wd_calc;
            end
          end
        end
        S_BUS: begin
          if (!waitrequest) begin
            read       <= 1'b0;
            write      <= 1'b0;
            state      <= S_RESP;
            resp_valid <= 1'b1;
            resp_error <= 1'b0;
            resp_rdata <= write_q ? 32'b0 : load_ext;
          end else if (counter == CW'(TIMEOUT - 1)) begin
            read       <= 1'b0;
            write      <= 1'b0;
            state      <= S_RESP;
            resp_valid <= 1'b1;
            resp_error <= 1'b1;
            resp_rdata <= '0;
          end else begin
            counter <= counter + CW'(1);
          end
        end
        S_RESP: begin
          state      <= S_IDLE;
          resp_valid <= 1'b0;
          resp_error <= 1'b0;
          resp_rdata <= '0;
          req_ready  <= 1'b1;
        end
        default: begin
          state     <= S_IDLE;
          read      <= 1'b0;
          write     <= 1'b0;
          req_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_bus_mem_unit.sv
// Bench for mips_bus_mem_unit: directed cases followed by random requests,
// each checked against an arithmetic model of the load/store rules.
module tb_mips_bus_mem_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic        waitrequest = 1'b0;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata = '0;

  int checks = 0;
  int failures = 0;

  mips_bus_mem_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_error(resp_error), .address(address), .read(read), .write(write),
    .waitrequest(waitrequest), .writedata(writedata), .byteenable(byteenable),
    .readdata(readdata)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=stuck expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One request end to end; nwait >= TO means waitrequest never drops
  task automatic txn(input logic w, input logic [1:0] sz, input logic sg,
                     input logic [31:0] a, input logic [31:0] wd,
                     input int nwait, input logic [31:0] rd);
    logic        err;
    logic        tmo;
    int          off;
    int          n;
    longint      v;
    logic [31:0] exp_be, exp_wd, exp_rd;
    off = int'(a % 4);
    err = (sz == 2'd3) || (sz == 2'd1 && off % 2 == 1) || (sz == 2'd2 && off != 0);
    tmo = (nwait >= TO);
    case (sz)
      2'd0:    begin exp_be = 32'd1 << off; exp_wd = (wd % 256) * 32'h01010101; end
      2'd1:    begin exp_be = 32'd3 << off; exp_wd = (wd % 65536) * 32'h00010001; end
      default: begin exp_be = 32'd15;       exp_wd = wd; end
    endcase
    v = 0;
    if (!w && !tmo) begin
      case (sz)
        2'd0: begin
          v = longint'((rd >> (8 * off)) % 256);
          if (sg && v >= 128) v = v - 256;
        end
        2'd1: begin
          v = longint'((rd >> (8 * off)) % 65536);
          if (sg && v >= 32768) v = v - 65536;
        end
        default: v = longint'(rd);
      endcase
    end
    exp_rd = v[31:0];

    req_write  = w;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
    req_valid  = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      tick();
      n++;
    end
    chk("ready_wait", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;

    if (err) begin
      chk("err_resp_valid", 32'(resp_valid), 32'd1);
      chk("err_resp_error", 32'(resp_error), 32'd1);
      chk("err_resp_rdata", resp_rdata, 32'd0);
      chk("err_no_strobe", 32'({read, write}), 32'd0);
      tick();
      chk("err_resp_pulse", 32'(resp_valid), 32'd0);
      chk("err_no_strobe2", 32'({read, write}), 32'd0);
      chk("err_ready_back", 32'(req_ready), 32'd1);
      return;
    end

    for (int k = 0; k < TO; k++) begin
      waitrequest = (k < nwait);
      readdata    = (k < nwait) ? $urandom : rd;
      chk("read", 32'(read), 32'(!w));
      chk("write", 32'(write), 32'(w));
      chk("address", address, a & 32'hFFFFFFFC);
      chk("byteenable", 32'(byteenable), exp_be);
      if (w) chk("writedata", writedata, exp_wd);
      chk("no_resp_in_bus", 32'(resp_valid), 32'd0);
      tick();
      if (k >= nwait) break;
    end
    waitrequest = 1'b0;
    readdata    = $urandom;
    chk("strobe_drop", 32'({read, write}), 32'd0);
    chk("resp_valid", 32'(resp_valid), 32'd1);
    chk("resp_error", 32'(resp_error), 32'(tmo));
    chk("resp_rdata", resp_rdata, exp_rd);
    tick();
    chk("resp_pulse", 32'(resp_valid), 32'd0);
    chk("ready_after", 32'(req_ready), 32'd1);
  endtask

  initial begin
    logic [1:0]  sz;
    logic [31:0] a;
    reset = 1'b0;
    repeat (3) tick();
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_strobes", 32'({read, write}), 32'd0);
    chk("rst_resp", 32'({resp_valid, resp_error}), 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_address", address, 32'd0);
    chk("rst_writedata", writedata, 32'd0);
    chk("rst_byteenable", 32'(byteenable), 32'd0);
    reset = 1'b1;
    tick();
    chk("ready_after_rst", 32'(req_ready), 32'd1);

    txn(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF, 0, 32'h0);
    txn(1'b0, 2'd0, 1'b1, 32'h203, 32'h0, 0, 32'h80112233);
    txn(1'b1, 2'd1, 1'b0, 32'h42, 32'h1234BEEF, 0, 32'h0);
    txn(1'b0, 2'd2, 1'b0, 32'h6, 32'h0, 0, 32'h0);
    txn(1'b0, 2'd1, 1'b0, 32'h10, 32'h0, 3, 32'h0000F00D);
    txn(1'b0, 2'd1, 1'b0, 32'h10, 32'h0, 100, 32'h0000F00D);
    txn(1'b0, 2'd3, 1'b0, 32'h20, 32'h0, 0, 32'h0);
    txn(1'b0, 2'd1, 1'b1, 32'h32, 32'h0, 1, 32'h8001_7FFF);
    txn(1'b0, 2'd0, 1'b0, 32'h201, 32'h0, 0, 32'h1122_9933);

    // reset while the bus is stalled: strobe drops, no response ever appears
    req_write = 1'b0; req_size = 2'd2; req_signed = 1'b0;
    req_addr = 32'h300; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    waitrequest = 1'b1;
    chk("rst_mid_read_on", 32'(read), 32'd1);
    reset = 1'b0;
    tick();
    chk("rst_mid_read_off", 32'(read), 32'd0);
    chk("rst_mid_no_resp", 32'(resp_valid), 32'd0);
    reset = 1'b1;
    waitrequest = 1'b0;
    tick();
    chk("rst_mid_ready", 32'(req_ready), 32'd1);
    repeat (3) begin
      tick();
      chk("rst_mid_quiet", 32'({resp_valid, read, write}), 32'd0);
    end

    for (int i = 0; i < 60; i++) begin
      sz = 2'($urandom_range(0, 3));
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd2) a = a & 32'hFFFFFFFC;
        if (sz == 2'd1) a = a & 32'hFFFFFFFE;
      end
      txn(1'($urandom), sz, 1'($urandom), a, $urandom, int'($urandom_range(0, 5)), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
